demux_1to4: RTL and testbench



---
 rtl/demux_pkg.sv | 18 +
 rtl/demux_if.sv | 34 +++
 rtl/demux_dec2to4.sv | 21 ++
 rtl/demux_1to4.sv | 58 +++++
 tb/tb_demux_1to4.sv | 107 ++++++++++
 5 files changed

// File: rtl/demux_pkg.sv
// Shared select encoding and helpers for the registered 1-to-4 demultiplexer.
package demux_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

  localparam int unsigned NUM_OUT = 4;

  // a is the select MSB, b the LSB
  function automatic sel_t make_sel(input logic a, input logic b);
    make_sel = {a, b};
  endfunction

endpackage

// File: rtl/demux_if.sv
// Data/select bundle between a source and the demultiplexer with its four destinations.
interface demux_if #(
  parameter int WIDTH = 1
) ();

  logic [WIDTH-1:0] din;
  logic             a;
  logic             b;
  logic [WIDTH-1:0] aout;
  logic [WIDTH-1:0] bout;
  logic [WIDTH-1:0] cout;
  logic [WIDTH-1:0] dout;

  modport master (
    output din,
    output a,
    output b,
    input  aout,
    input  bout,
    input  cout,
    input  dout
  );

  modport slave (
    input  din,
    input  a,
    input  b,
    output aout,
    output bout,
    output cout,
    output dout
  );

endinterface

// File: rtl/demux_dec2to4.sv
// Combinational 2-to-4 one-hot decoder; every select value enables exactly one lane.
module demux_dec2to4
  import demux_pkg::*;
(
  input  sel_t       sel,
  output logic [3:0] en
);

  // One-hot decode of the lane select
  always_comb begin
    en = 4'b0000;
    case (sel)
      SEL_A:   en = 4'b0001;
      SEL_B:   en = 4'b0010;
      SEL_C:   en = 4'b0100;
      SEL_D:   en = 4'b1000;
      default: en = 4'b0000;
    endcase
  end

endmodule

// File: rtl/demux_1to4.sv
// Registered 1-to-4 demultiplexer: din is steered to the register chosen by {a,b};
// the other three are cleared or held depending on HOLD_UNSELECTED.
module demux_1to4
  import demux_pkg::*;
#(
  parameter int WIDTH           = 1,
  parameter bit HOLD_UNSELECTED = 1'b0
) (
  input  logic   clk,
  input  logic   rst,
  demux_if.slave bus
);

  sel_t             sel_s;
  logic [3:0]       en_s;
  logic [WIDTH-1:0] nxt_s [NUM_OUT];
  logic [WIDTH-1:0] out_r [NUM_OUT];

  assign sel_s = make_sel(bus.a, bus.b);

  demux_dec2to4 u_dec (
    .sel (sel_s),
    .en  (en_s)
  );

  // Next value per lane: selected lane takes din, others clear or hold
  always_comb begin
    for (int i = 0; i < NUM_OUT; i++) begin
      nxt_s[i] = {WIDTH{1'b0}};
      if (en_s[i]) begin
        nxt_s[i] = bus.din;
      end else if (HOLD_UNSELECTED) begin
        nxt_s[i] = out_r[i];
      end else begin
        nxt_s[i] = {WIDTH{1'b0}};
      end
    end
  end

  // Output registers; reset wins over routing on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        out_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        out_r[i] <= nxt_s[i];
      end
    end
  end

  assign bus.aout = out_r[SEL_A];
  assign bus.bout = out_r[SEL_B];
  assign bus.cout = out_r[SEL_C];
  assign bus.dout = out_r[SEL_D];

endmodule

// File: tb/tb_demux_1to4.sv
// Directed bench: clear-mode and hold-mode 1-bit instances plus an 8-bit instance,
// all driven with the same select sequence and checked against hand-computed values.
module tb_demux_1to4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  demux_if #(.WIDTH(1)) if0 ();
  demux_if #(.WIDTH(1)) if1 ();
  demux_if #(.WIDTH(8)) if8 ();

  demux_1to4 #(.WIDTH(1), .HOLD_UNSELECTED(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  demux_1to4 #(.WIDTH(1), .HOLD_UNSELECTED(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  demux_1to4 #(.WIDTH(8), .HOLD_UNSELECTED(1'b0)) dut8 (.clk(clk), .rst(rst), .bus(if8));

  task automatic drive(input logic [7:0] d, input logic [1:0] s);
    if0.din = d[0]; if0.a = s[1]; if0.b = s[0];
    if1.din = d[0]; if1.a = s[1]; if1.b = s[0];
    if8.din = d;    if8.a = s[1]; if8.b = s[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected nibbles are {aout,bout,cout,dout}
  task automatic chk0(input string tag, input logic [3:0] exp);
    chk({"clr ", tag}, {28'd0, if0.aout, if0.bout, if0.cout, if0.dout}, {28'd0, exp});
  endtask

  task automatic chk1(input string tag, input logic [3:0] exp);
    chk({"hold ", tag}, {28'd0, if1.aout, if1.bout, if1.cout, if1.dout}, {28'd0, exp});
  endtask

  task automatic chk8(input string tag, input logic [31:0] exp);
    chk({"w8 ", tag}, {if8.aout, if8.bout, if8.cout, if8.dout}, exp);
  endtask

  initial begin
    drive(8'h01, 2'b00);
    rst = 1'b1;
    tick();
    chk0("rst1", 4'b0000); chk1("rst1", 4'b0000); chk8("rst1", 32'h00000000);
    tick();
    chk0("rst2", 4'b0000); chk1("rst2", 4'b0000); chk8("rst2", 32'h00000000);
    rst = 1'b0;
    tick();
    chk0("release", 4'b1000); chk1("release", 4'b1000); chk8("release", 32'h01000000);

    drive(8'h01, 2'b01); tick();
    chk0("sweep1 01", 4'b0100); chk1("sweep1 01", 4'b1100);
    drive(8'h01, 2'b10); tick();
    chk0("sweep1 10", 4'b0010); chk1("sweep1 10", 4'b1110);
    drive(8'h01, 2'b11); tick();
    chk0("sweep1 11", 4'b0001); chk1("sweep1 11", 4'b1111); chk8("sweep1 11", 32'h00000001);

    drive(8'h00, 2'b00); tick();
    chk0("sweep0 00", 4'b0000); chk1("sweep0 00", 4'b0111);
    drive(8'h00, 2'b01); tick();
    chk0("sweep0 01", 4'b0000); chk1("sweep0 01", 4'b0011);
    drive(8'h00, 2'b10); tick();
    chk0("sweep0 10", 4'b0000); chk1("sweep0 10", 4'b0001);
    drive(8'h00, 2'b11); tick();
    chk0("sweep0 11", 4'b0000); chk1("sweep0 11", 4'b0000);

    drive(8'h01, 2'b10); tick();
    chk0("track 1", 4'b0010); chk1("track 1", 4'b0010);
    drive(8'h00, 2'b10); tick();
    chk0("track 0", 4'b0000); chk1("track 0", 4'b0000);
    drive(8'h01, 2'b10); tick();
    chk0("track 1b", 4'b0010); chk1("track 1b", 4'b0010);
    drive(8'h01, 2'b10); tick();
    chk0("track 1c", 4'b0010); chk1("track 1c", 4'b0010);

    drive(8'h01, 2'b11); tick();
    chk0("pre midrst", 4'b0001); chk1("pre midrst", 4'b0011);
    rst = 1'b1; tick();
    chk0("midrst", 4'b0000); chk1("midrst", 4'b0000); chk8("midrst", 32'h00000000);
    rst = 1'b0; tick();
    chk0("post midrst", 4'b0001); chk1("post midrst", 4'b0001); chk8("post midrst", 32'h00000001);

    drive(8'hA5, 2'b01); tick();
    chk8("A5 sel01", 32'h00A50000);
    chk0("A5 sel01", 4'b0100); chk1("A5 sel01", 4'b0101);
    drive(8'h3C, 2'b10); tick();
    chk8("3C sel10", 32'h00003C00);
    drive(8'hFF, 2'b00); tick();
    chk8("FF sel00", 32'hFF000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
